tile_renderer: RTL and testbench
================================

TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 SHALL have parameters: BDR=0, SKY=1, BLK=2, GND=3, TKN=4, CK1=5, CK2=6 (tile codes); SCREEN_WIDTH=640; SCREEN_HEIGHT=480; BLOCK_WIDTH=40; CHARACTER_WIDTH=42.
REQ-002 SHALL have colour parameters (12-bit RGB444): C_BDR=12'h000, C_SKY=12'h6AF, C_BLK=12'hA52, C_GND=12'h850, C_TKN=12'hFD0, C_CK1=12'hFFF, C_CK2=12'hCCC, C_MARIO=12'hF00, C_GOOMBA=12'h840, C_BAD=12'hF0F.
REQ-003 vga_clock  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 pixel_en  in  1  one scan pixel presented this cycle.
REQ-006 line_start  in  1  qualifies pixel_en; pixel is column 0 of next line.
REQ-007 frame_start  in  1  qualifies pixel_en; pixel is (0,0) of a new frame.
REQ-008 background  in  byte [11:0][16:0]  tile map.
REQ-009 mario_x, mario_y, goomba_x, goomba_y  in  int  signed sprite top-left, pixels.
REQ-010 win, lose  in  1  level status.
REQ-011 rgb  out  12  pixel colour.
REQ-012 rgb_valid  out  1  rgb corresponds to a pixel_en two cycles earlier.

Function
REQ-013 Scan counters px, py SHALL track accepted pixels: frame_start -> (0,0); line_start without frame_start -> (0, py+1); else (px+1, py); frame_start dominates line_start; pixel_en low -> hold.
REQ-014 px SHALL saturate at SCREEN_WIDTH, py at SCREEN_HEIGHT; any pixel with px>=SCREEN_WIDTH or py>=SCREEN_HEIGHT SHALL render C_BDR.
REQ-015 Tile lookup SHALL use incremental sub-counters (0..BLOCK_WIDTH-1) for column/row, no dividers: screen tile column c=px/40 (0..15), row r=py/40 (0..11); code = background[11-r][16-c]; array column 0 never displayed.
REQ-016 On each frame_start pixel, mario/goomba positions, win and lose SHALL be snapshot and used for that whole frame; sprites SHALL be hidden until first frame_start after reset.
REQ-017 Sprite hit: x<=px<x+CHARACTER_WIDTH and y<=py<y+CHARACTER_WIDTH, 32-bit signed compare; negative/off-screen positions legal.
REQ-018 Priority: mario > goomba > tile.
REQ-019 Tile colour by code; codes >6 SHALL give C_BAD.
REQ-020 6-bit frame_count SHALL increment on each frame_start, wrap 63->0; TKN SHALL render C_TKN when frame_count[4]==0, else C_SKY.
REQ-021 Snapshot lose=1: BDR tiles render 12'hF00; else win=1: 12'h0F0; lose overrides win.
REQ-022 Pipeline SHALL be 2 stages, fixed: S1 registers tile code, hit flags, range flag; S2 registers rgb; rgb_valid = pixel_en delayed 2 cycles; no back-pressure.
REQ-023 rgb SHALL be 12'h000 whenever rgb_valid=0.
REQ-024 Back-to-back pixel_en every cycle SHALL be sustained with no bubbles.

Reset
REQ-025 reset=1 SHALL within one edge clear px, py, sub-counters, frame_count, snapshots, sprite-enable, both pipeline valids; rgb=0, rgb_valid=0 on the following cycle.
REQ-026 Reset mid-frame SHALL discard in-flight pixels (no rgb_valid for them); rendering resumes only from the next frame_start.

Verification
REQ-027 Reset, then frame_start+pixel_en with background[11][16]=SKY, sprites at (200,200) -> two cycles later rgb_valid=1, rgb=12'h6AF.
REQ-028 Mario (0,0), goomba (0,0), stream pixels 0..41 of line 0 -> all 12'hF00; pixel 42 -> tile colour; move mario mid-frame to (300,0) -> no change until next frame_start.
REQ-029 background[11][15]=TKN, stream frames 1..40 -> pixel (40,0) shows 12'hFD0 for frame_count 0..15, 12'h6AF for 16..31, 12'hFD0 for 32..47.
REQ-030 lose=1 and win=1 at frame_start, BDR tile at (0,0) -> 12'hF00; win only -> 12'h0F0; lose rising mid-frame -> applies next frame only.
REQ-031 700 pixel_en after line_start with no further line_start -> pixels 640..699 render 12'h000, px holds; frame_start+line_start together -> pixel treated as (0,0).
REQ-032 Assert reset one cycle while two pixels in flight -> rgb_valid stays 0 for both; tile code 7 at visible tile -> 12'hF0F.

Source files
------------

// File: rtl/tile_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tile_renderer
//  Purpose  : Two-stage pixel colour pipeline for a tile-map game screen.
//             Tracks the raster position of each accepted scan pixel, looks
//             up the background tile under it, overlays the Mario and Goomba
//             sprites and emits an RGB444 colour two cycles later.
//  Ports    : vga_clock              - sole clock, rising edge
//             reset                  - synchronous, active-high
//             pixel_en               - one scan pixel presented this cycle
//             line_start/frame_start - qualify pixel_en (column 0 / origin)
//             background             - 12 x 17 tile map, one byte per tile
//             mario_*/goomba_*       - signed sprite top-left, pixels
//             win, lose              - level status (sampled per frame)
//             rgb, rgb_valid         - pixel colour and its qualifier
//  Revision : 1.0  initial release
// ============================================================================
module tile_renderer #(
   parameter int BDR             = 0,
   parameter int SKY             = 1,
   parameter int BLK             = 2,
   parameter int GND             = 3,
   parameter int TKN             = 4,
   parameter int CK1             = 5,
   parameter int CK2             = 6,
   parameter int SCREEN_WIDTH    = 640,
   parameter int SCREEN_HEIGHT   = 480,
   parameter int BLOCK_WIDTH     = 40,
   parameter int CHARACTER_WIDTH = 42,
   parameter logic [11:0] C_BDR    = 12'h000,
   parameter logic [11:0] C_SKY    = 12'h6AF,
   parameter logic [11:0] C_BLK    = 12'hA52,
   parameter logic [11:0] C_GND    = 12'h850,
   parameter logic [11:0] C_TKN    = 12'hFD0,
   parameter logic [11:0] C_CK1    = 12'hFFF,
   parameter logic [11:0] C_CK2    = 12'hCCC,
   parameter logic [11:0] C_MARIO  = 12'hF00,
   parameter logic [11:0] C_GOOMBA = 12'h840,
   parameter logic [11:0] C_BAD    = 12'hF0F
) (
   input  logic                      vga_clock,
   input  logic                      reset,
   input  logic                      pixel_en,
   input  logic                      line_start,
   input  logic                      frame_start,
   input  logic [11:0][16:0][7:0]    background,
   input  logic signed [31:0]        mario_x,
   input  logic signed [31:0]        mario_y,
   input  logic signed [31:0]        goomba_x,
   input  logic signed [31:0]        goomba_y,
   input  logic                      win,
   input  logic                      lose,
   output logic [11:0]               rgb,
   output logic                      rgb_valid
);

   localparam int PXW  = $clog2(SCREEN_WIDTH + 1);
   localparam int PYW  = $clog2(SCREEN_HEIGHT + 1);
   localparam int SUBW = $clog2(BLOCK_WIDTH);
   localparam logic [PXW-1:0]    C_PX_MAX   = PXW'(SCREEN_WIDTH);
   localparam logic [PYW-1:0]    C_PY_MAX   = PYW'(SCREEN_HEIGHT);
   localparam logic [SUBW-1:0]   C_SUB_LAST = SUBW'(BLOCK_WIDTH - 1);
   localparam logic signed [31:0] C_CW      = 32'(CHARACTER_WIDTH);

   // Raster position of the most recently accepted pixel, plus the tile
   // column/row and the offset inside that tile (replaces division by 40).
   logic [PXW-1:0]  px_q, px_d;
   logic [PYW-1:0]  py_q, py_d;
   logic [SUBW-1:0] csub_q, csub_d, rsub_q, rsub_d;
   logic [4:0]      col_q, col_d, row_q, row_d;

   // Per-frame snapshot
   logic [5:0]         fc_q, fc_d;
   logic               spr_en_q, spr_en_d;
   logic               win_q, win_d, lose_q, lose_d;
   logic signed [31:0] mx_q, mx_d, my_q, my_d, gx_q, gx_d, gy_q, gy_d;

   // Stage 1 / stage 2 pipeline registers
   logic [7:0]  code_q;
   logic        mhit_q, ghit_q, inr_q, tkn_on_q, win1_q, lose1_q, v1_q;
   logic [11:0] rgb_q;
   logic        v2_q;

   logic               w_fs;
   logic               w_inr;
   logic               w_mhit, w_ghit;
   logic signed [31:0] w_px_s, w_py_s;
   logic [3:0]         w_ri;
   logic [4:0]         w_ci;
   logic [7:0]         w_code;
   logic [11:0]        w_rgb;

   assign w_fs = pixel_en & frame_start;

   // Scan counters; the _d values are the coordinates of the pixel being
   // accepted this cycle, so stage 1 works from them directly.
   always_comb begin
      px_d   = px_q;
      py_d   = py_q;
      csub_d = csub_q;
      rsub_d = rsub_q;
      col_d  = col_q;
      row_d  = row_q;
      if (pixel_en) begin
         if (frame_start) begin
            px_d   = '0;
            py_d   = '0;
            csub_d = '0;
            rsub_d = '0;
            col_d  = '0;
            row_d  = '0;
         end else if (line_start) begin
            px_d   = '0;
            csub_d = '0;
            col_d  = '0;
            if (py_q < C_PY_MAX) begin
               py_d = py_q + 1'b1;
               if (rsub_q == C_SUB_LAST) begin
                  rsub_d = '0;
                  row_d  = row_q + 5'd1;
               end else begin
                  rsub_d = rsub_q + 1'b1;
               end
            end
         end else if (px_q < C_PX_MAX) begin
            px_d = px_q + 1'b1;
            if (csub_q == C_SUB_LAST) begin
               csub_d = '0;
               col_d  = col_q + 5'd1;
            end else begin
               csub_d = csub_q + 1'b1;
            end
         end
      end
   end

   // A frame_start pixel already sees the values it snapshots.
   assign fc_d     = w_fs ? fc_q + 6'd1 : fc_q;
   assign spr_en_d = spr_en_q | w_fs;
   assign win_d    = w_fs ? win      : win_q;
   assign lose_d   = w_fs ? lose     : lose_q;
   assign mx_d     = w_fs ? mario_x  : mx_q;
   assign my_d     = w_fs ? mario_y  : my_q;
   assign gx_d     = w_fs ? goomba_x : gx_q;
   assign gy_d     = w_fs ? goomba_y : gy_q;

   assign w_px_s = $signed({{(32-PXW){1'b0}}, px_d});
   assign w_py_s = $signed({{(32-PYW){1'b0}}, py_d});
   assign w_inr  = (px_d < C_PX_MAX) && (py_d < C_PY_MAX);

   assign w_mhit = spr_en_d && (w_px_s >= mx_d) && (w_px_s < mx_d + C_CW)
                            && (w_py_s >= my_d) && (w_py_s < my_d + C_CW);
   assign w_ghit = spr_en_d && (w_px_s >= gx_d) && (w_px_s < gx_d + C_CW)
                            && (w_py_s >= gy_d) && (w_py_s < gy_d + C_CW);

   // Map is stored bottom-row-first and right-to-left; array column 0 is
   // never on screen. Out-of-range indices only occur off-screen, where the
   // range flag forces the border colour anyway.
   assign w_ri   = 4'd11 - row_d[3:0];
   assign w_ci   = 5'd16 - col_d;
   assign w_code = w_inr ? background[w_ri][w_ci] : 8'd0;

   // Stage 2 colour selection
   always_comb begin
      w_rgb = C_BDR;
      if (!inr_q) begin
         w_rgb = C_BDR;
      end else if (mhit_q) begin
         w_rgb = C_MARIO;
      end else if (ghit_q) begin
         w_rgb = C_GOOMBA;
      end else begin
         case (code_q)
            8'(BDR): w_rgb = lose1_q ? 12'hF00 : (win1_q ? 12'h0F0 : C_BDR);
            8'(SKY): w_rgb = C_SKY;
            8'(BLK): w_rgb = C_BLK;
            8'(GND): w_rgb = C_GND;
            8'(TKN): w_rgb = tkn_on_q ? C_TKN : C_SKY;
            8'(CK1): w_rgb = C_CK1;
            8'(CK2): w_rgb = C_CK2;
            default: w_rgb = C_BAD;
         endcase
      end
   end

   always_ff @(posedge vga_clock) begin
      if (reset) begin
         px_q     <= '0;
         py_q     <= '0;
         csub_q   <= '0;
         rsub_q   <= '0;
         col_q    <= '0;
         row_q    <= '0;
         fc_q     <= '0;
         spr_en_q <= 1'b0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
         mx_q     <= '0;
         my_q     <= '0;
         gx_q     <= '0;
         gy_q     <= '0;
         code_q   <= '0;
         mhit_q   <= 1'b0;
         ghit_q   <= 1'b0;
         inr_q    <= 1'b0;
         tkn_on_q <= 1'b0;
         win1_q   <= 1'b0;
         lose1_q  <= 1'b0;
         v1_q     <= 1'b0;
         rgb_q    <= '0;
         v2_q     <= 1'b0;
      end else begin
         px_q     <= px_d;
         py_q     <= py_d;
         csub_q   <= csub_d;
         rsub_q   <= rsub_d;
         col_q    <= col_d;
         row_q    <= row_d;
         fc_q     <= fc_d;
         spr_en_q <= spr_en_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
         mx_q     <= mx_d;
         my_q     <= my_d;
         gx_q     <= gx_d;
         gy_q     <= gy_d;
         code_q   <= w_code;
         mhit_q   <= w_mhit;
         ghit_q   <= w_ghit;
         inr_q    <= w_inr;
         tkn_on_q <= ~fc_d[4];
         win1_q   <= win_d;
         lose1_q  <= lose_d;
         v1_q     <= pixel_en;
         rgb_q    <= v1_q ? w_rgb : 12'h000;
         v2_q     <= v1_q;
      end
   end

   assign rgb       = rgb_q;
   assign rgb_valid = v2_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tile_renderer
//  Purpose  : Self-checking bench for tile_renderer. A screen-level model
//             (integer raster position, division for tile lookup, per-frame
//             snapshot) predicts every output cycle; directed scenarios add
//             hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tile_renderer;

   logic                   clk;
   logic                   reset;
   logic                   pixel_en, line_start, frame_start;
   logic [11:0][16:0][7:0] bg;
   logic signed [31:0]     mario_x, mario_y, goomba_x, goomba_y;
   logic                   win, lose;
   logic [11:0]            rgb;
   logic                   rgb_valid;

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_en   = 0;

   tile_renderer dut (
      .vga_clock  (clk),
      .reset      (reset),
      .pixel_en   (pixel_en),
      .line_start (line_start),
      .frame_start(frame_start),
      .background (bg),
      .mario_x    (mario_x),
      .mario_y    (mario_y),
      .goomba_x   (goomba_x),
      .goomba_y   (goomba_y),
      .win        (win),
      .lose       (lose),
      .rgb        (rgb),
      .rgb_valid  (rgb_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int  m_px, m_py, m_fc;
   bit  m_started, m_win, m_lose;
   int  m_mx, m_my, m_gx, m_gy;
   bit  m_v1, m_v2;
   logic [11:0] m_rgb1, m_rgb2;

   function automatic bit inside_spr(int x, int y, int sx, int sy);
      return (x >= sx) && (x < sx + 42) && (y >= sy) && (y < sy + 42);
   endfunction

   function automatic logic [11:0] m_color(int x, int y);
      int code;
      if (x >= 640 || y >= 480) return 12'h000;
      if (m_started && inside_spr(x, y, m_mx, m_my)) return 12'hF00;
      if (m_started && inside_spr(x, y, m_gx, m_gy)) return 12'h840;
      code = int'(bg[11 - y / 40][16 - x / 40]);
      case (code)
         0: return m_lose ? 12'hF00 : (m_win ? 12'h0F0 : 12'h000);
         1: return 12'h6AF;
         2: return 12'hA52;
         3: return 12'h850;
         4: return ((m_fc / 16) % 2 == 0) ? 12'hFD0 : 12'h6AF;
         5: return 12'hFFF;
         6: return 12'hCCC;
         default: return 12'hF0F;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            m_px = 0; m_py = 0; m_fc = 0;
            m_started = 0; m_win = 0; m_lose = 0;
            m_mx = 0; m_my = 0; m_gx = 0; m_gy = 0;
            m_v1 = 0; m_v2 = 0; m_rgb1 = '0; m_rgb2 = '0;
         end else begin
            m_v2   = m_v1;
            m_rgb2 = m_v1 ? m_rgb1 : 12'h000;
            if (pixel_en) begin
               if (frame_start) begin
                  m_px = 0; m_py = 0;
                  m_fc = (m_fc + 1) % 64;
                  m_started = 1;
                  m_win = win; m_lose = lose;
                  m_mx = mario_x; m_my = mario_y;
                  m_gx = goomba_x; m_gy = goomba_y;
               end else if (line_start) begin
                  m_px = 0;
                  if (m_py < 480) m_py = m_py + 1;
               end else if (m_px < 640) begin
                  m_px = m_px + 1;
               end
               m_rgb1 = m_color(m_px, m_py);
               m_v1   = 1;
            end else begin
               m_v1 = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            n_checks++;
            if (rgb_valid !== m_v2 || rgb !== m_rgb2) begin
               n_err++;
               $display("FAIL cycle_cmp t=%0t got rgb=%h valid=%b, want rgb=%h valid=%b",
                        $time, rgb, rgb_valid, m_rgb2, m_v2);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", name, got, exp);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit en, input bit ls, input bit fs);
      pixel_en = en; line_start = ls; frame_start = fs;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; pixel_en = 0; line_start = 0; frame_start = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Stream pixels 0..n-1 of a line (first one optionally a frame start),
   // then one idle cycle; c is the colour of pixel n-1.
   task automatic shot(input bit fs, input int n, output logic [11:0] c);
      drive(1, 0, fs);
      repeat (n - 1) drive(1, 0, 0);
      drive(0, 0, 0);
      c = rgb;
   endtask

   task automatic fill_bg(input logic [7:0] code);
      for (int r = 0; r < 12; r++)
         for (int k = 0; k < 17; k++)
            bg[r][k] = code;
   endtask

   task automatic sprites_away();
      mario_x = -100; mario_y = -100; goomba_x = -100; goomba_y = -100;
   endtask

   task automatic rand_phase(input int cycles, input int fs_div, input int ls_div);
      for (int i = 0; i < cycles; i++) begin
         if ($urandom_range(199) == 0) begin
            mario_x  = int'($urandom_range(760)) - 60;
            mario_y  = int'($urandom_range(560)) - 60;
            goomba_x = int'($urandom_range(760)) - 60;
            goomba_y = int'($urandom_range(560)) - 60;
         end
         if ($urandom_range(99) == 0) begin
            win  = 1'($urandom_range(1));
            lose = 1'($urandom_range(1));
         end
         if ($urandom_range(49) == 0)
            bg[$urandom_range(11)][$urandom_range(16)] = 8'($urandom_range(8));
         reset = ($urandom_range(2999) == 0);
         drive(($urandom_range(7) != 0),
               ($urandom_range(ls_div - 1) == 0),
               ($urandom_range(fs_div - 1) == 0));
      end
      reset = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   logic [11:0] c;

   initial begin
      reset = 1'b1; pixel_en = 0; line_start = 0; frame_start = 0;
      win = 0; lose = 0;
      fill_bg(8'd1);
      mario_x = 200; mario_y = 200; goomba_x = 200; goomba_y = 200;
      @(negedge clk);
      cmp_en = 1;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_rgb", rgb, 12'h000);
      chk("reset_valid", {11'b0, rgb_valid}, 12'h000);

      // first frame_start pixel over a SKY tile
      shot(1, 1, c);
      chk("sky_first", c, 12'h6AF);

      // sprites at origin: last Mario pixel, first tile pixel, mid-frame move
      mario_x = 0; mario_y = 0; goomba_x = 0; goomba_y = 0;
      bg[11][15] = 8'd3;
      shot(1, 42, c);
      chk("mario_px41", c, 12'hF00);
      shot(1, 43, c);
      chk("tile_px42", c, 12'h850);
      mario_x = 300;
      repeat (278) drive(1, 0, 0);
      drive(0, 0, 0);
      chk("mid_move_px320", rgb, 12'h6AF);
      shot(1, 301, c);
      chk("moved_px300", c, 12'hF00);

      // token blink over frames 1..40
      do_reset();
      sprites_away();
      fill_bg(8'd1);
      bg[11][15] = 8'd4;
      for (int f = 1; f <= 40; f++) begin
         shot(1, 41, c);
         if (f == 1 || f == 15 || f == 16 || f == 31 || f == 32 || f == 40)
            chk($sformatf("token_f%0d", f), c, (f < 16 || f >= 32) ? 12'hFD0 : 12'h6AF);
      end

      // win / lose on a border tile
      bg[11][16] = 8'd0;
      win = 1; lose = 1;
      shot(1, 1, c);
      chk("lose_over_win", c, 12'hF00);
      lose = 0;
      shot(1, 1, c);
      chk("win_only", c, 12'h0F0);
      lose = 1;
      drive(1, 0, 0);
      drive(0, 0, 0);
      chk("lose_mid_frame", rgb, 12'h0F0);
      shot(1, 1, c);
      chk("lose_next_frame", c, 12'hF00);

      // 700 pixels on one line: px saturates at 640
      win = 0; lose = 0;
      fill_bg(8'd1);
      drive(1, 0, 1);
      drive(1, 1, 0);
      repeat (699) drive(1, 0, 0);
      drive(0, 0, 0);
      chk("sat_px_rgb", rgb, 12'h000);
      chk("sat_px_valid", {11'b0, rgb_valid}, 12'h001);

      // frame_start with line_start -> (0,0); Mario covers row 0 only
      mario_x = 0; mario_y = -41;
      drive(1, 1, 1);
      drive(0, 0, 0);
      chk("fs_ls_origin", rgb, 12'hF00);

      // reset with pixels in flight
      sprites_away();
      drive(1, 0, 1);
      drive(1, 0, 0);
      reset = 1'b1; pixel_en = 1'b1;
      @(negedge clk);
      reset = 1'b0; pixel_en = 1'b0;
      chk("flush_valid_a", {11'b0, rgb_valid}, 12'h000);
      drive(0, 0, 0);
      chk("flush_valid_b", {11'b0, rgb_valid}, 12'h000);

      // undefined tile code
      bg[11][16] = 8'd7;
      shot(1, 1, c);
      chk("bad_code", c, 12'hF0F);

      // randomized traffic
      for (int r = 0; r < 12; r++)
         for (int k = 0; k < 17; k++)
            bg[r][k] = 8'($urandom_range(8));
      rand_phase(6000, 400, 50);
      rand_phase(12000, 1500, 3);
      drive(0, 0, 0);
      drive(0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
